// File: rtl/svga_pkg.sv
// Shared constants for the 800x600 framebuffer path: display timing, line fetch
// geometry, FIFO sizing and the arbiter state encoding.
package svga_pkg;

  localparam int H_VISIBLE = 800;
  localparam int H_FRONT   = 40;
  localparam int H_SYNC    = 128;
  localparam int H_BACK    = 88;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_VISIBLE = 600;
  localparam int V_FRONT   = 1;
  localparam int V_SYNC    = 4;
  localparam int V_BACK    = 23;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // One 16-bit framebuffer word carries four 4-bpp pixels.
  localparam int PIX_PER_WORD      = 4;
  localparam int LINE_WORDS_DEF    = H_VISIBLE / PIX_PER_WORD;
  localparam int FIFO_DEPTH_DEF    = 16;
  localparam int HOST_MAX_WAIT_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/svga_word_fifo.sv
// Synchronous pixel-word FIFO with flush; head word is visible combinationally
// and reads as zero while empty.
module svga_word_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  // Flush takes precedence over any push or pop landing on the same edge.
  assign do_push = push_i && !flush_i && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/svga_fb_arbiter.sv
// Single-port framebuffer arbiter: interleaves display line prefetch into a
// pixel FIFO with host writes, bounding host wait to HOST_MAX_WAIT cycles.
module svga_fb_arbiter
  import svga_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int LINE_WORDS    = LINE_WORDS_DEF,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
  parameter int HOST_MAX_WAIT = HOST_MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] line_base,
  input  logic              pix_rd,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_empty,
  output logic              underrun,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        dbg_state
);

  localparam int REM_W  = $clog2(LINE_WORDS + 1);
  localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q;
  logic [REM_W-1:0]  remaining_q;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              rd_pend_q;
  logic              underrun_q;
  logic              ram_re_q, ram_we_q, host_ack_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [CNT_W:0]    occupancy;
  logic              host_pend;
  logic              fetch_ok;

  // Host handshake: host_req/host_addr/host_wdata are held until host_ack, a
  // one-cycle pulse coinciding with ram_we; the req still high during that
  // ack cycle is not treated as a new request.
  always_comb begin
    host_pend  = host_req && !host_ack_q;
    // Reads issued but not yet in the FIFO reserve a slot so a push never overflows.
    occupancy  = {1'b0, fifo_count} + (CNT_W+1)'(ram_re_q) + (CNT_W+1)'(rd_pend_q);
    fetch_ok   = !line_start && (remaining_q != '0) &&
                 (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    state_d    = ST_IDLE;
    if (host_pend && (wait_cnt_q == WAIT_W'(HOST_MAX_WAIT))) begin
      state_d = ST_WRITE;
    end else if (fetch_ok) begin
      state_d = ST_FETCH;
    end else if (host_pend) begin
      state_d = ST_WRITE;
    end
    wait_cnt_d = wait_cnt_q;
    if (!host_pend || (state_d == ST_WRITE)) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_W'(HOST_MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      fetch_addr_q <= '0;
      remaining_q  <= '0;
      rd_pend_q    <= 1'b0;
      underrun_q   <= 1'b0;
      ram_re_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      host_ack_q   <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ram_re_q   <= (state_d == ST_FETCH);
      ram_we_q   <= (state_d == ST_WRITE);
      host_ack_q <= (state_d == ST_WRITE);
      // A read still in the RAM pipeline when a new line starts is dropped.
      rd_pend_q  <= ram_re_q && !line_start;
      if (state_d == ST_WRITE) begin
        ram_addr_q  <= host_addr;
        ram_wdata_q <= host_wdata;
      end else if (state_d == ST_FETCH) begin
        ram_addr_q  <= fetch_addr_q;
      end
      if (line_start) begin
        fetch_addr_q <= line_base;
        remaining_q  <= REM_W'(LINE_WORDS);
      end else if (state_d == ST_FETCH) begin
        fetch_addr_q <= fetch_addr_q + 1'b1;
        remaining_q  <= remaining_q - 1'b1;
      end
      if (pix_rd && fifo_empty) begin
        underrun_q <= 1'b1;
      end
    end
  end

  svga_word_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (line_start),
    .push_i      (rd_pend_q),
    .push_data_i (ram_rdata),
    .pop_i       (pix_rd),
    .head_o      (pix_data),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign pix_empty = fifo_empty;
  assign underrun  = underrun_q;
  assign host_ack  = host_ack_q;
  assign ram_re    = ram_re_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_svga_fb_arbiter.sv
// Bench for svga_fb_arbiter: synchronous RAM model, line/host drivers, and a
// negedge monitor popping expected reads, pixel words and host writes.
module tb_svga_fb_arbiter;
  import svga_pkg::*;

  localparam int LW = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [15:0] line_base;
  logic        pix_rd;
  logic [15:0] pix_data;
  logic        pix_empty;
  logic        underrun;
  logic        host_req;
  logic [15:0] host_addr;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [15:0] ram_rdata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int reads_in_line = 0;
  int pops_in_line = 0;

  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_pix_q[$];
  logic [31:0] exp_wr_q[$];

  svga_fb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .line_base  (line_base),
    .pix_rd     (pix_rd),
    .pix_data   (pix_data),
    .pix_empty  (pix_empty),
    .underrun   (underrun),
    .host_req   (host_req),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_re     (ram_re),
    .ram_rdata  (ram_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model ----------------
  function automatic logic [15:0] ram_fn(input logic [15:0] a);
    return a * 16'd40503 + 16'h1234;
  endfunction

  always @(posedge clk) begin
    ram_rdata <= ram_re ? ram_fn(ram_addr) : 16'hDEAD;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_line(input logic [15:0] base);
    @(posedge clk); #1;
    line_start = 1'b1;
    line_base  = base;
    @(posedge clk); #1;
    line_start = 1'b0;
    exp_addr_q.delete();
    exp_pix_q.delete();
    for (int i = 0; i < LW; i++) begin
      logic [15:0] a;
      a = base + 16'(i);
      exp_addr_q.push_back(a);
      exp_pix_q.push_back(ram_fn(a));
    end
    reads_in_line = 0;
    pops_in_line  = 0;
  endtask

  task automatic drain_line();
    int cyc;
    cyc = 0;
    while (pops_in_line < LW && cyc < 4000) begin
      @(posedge clk); #1;
      pix_rd = !pix_empty && ($urandom_range(0, 3) != 0);
      cyc++;
    end
    @(posedge clk); #1;
    pix_rd = 1'b0;
    check("line_pops", pops_in_line, LW);
    check("line_reads_left", exp_addr_q.size(), 0);
  endtask

  task automatic run_line(input logic [15:0] base);
    start_line(base);
    drain_line();
  endtask

  task automatic host_write(input logic [15:0] a, input logic [15:0] d);
    int lat;
    @(posedge clk); #1;
    host_req   = 1'b1;
    host_addr  = a;
    host_wdata = d;
    exp_wr_q.push_back({a, d});
    lat = 0;
    forever begin
      @(negedge clk);
      if (host_ack || lat > 30) break;
      lat++;
    end
    check("host_ack_latency_le9", 32'(lat <= 9), 1);
    @(posedge clk); #1;
    host_req = 1'b0;
  endtask

  task automatic host_traffic(input int n);
    repeat (n) begin
      repeat ($urandom_range(0, 15)) @(posedge clk);
      host_write({4'h8, 12'($urandom)}, 16'($urandom));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset  = 1'b1;
    pix_rd = 1'b0;
    repeat (2) @(negedge clk);
    exp_addr_q.delete();
    exp_pix_q.delete();
    exp_wr_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [31:0] w;
    if (!reset) begin
      check("one_access", 32'(ram_re & ram_we), 0);
      if (ram_re) begin
        reads_in_line++;
        check("fetch_state", 32'(dbg_state), 32'(ST_FETCH));
        check("read_expected", 32'(exp_addr_q.size() != 0), 1);
        if (exp_addr_q.size() != 0) check("rd_addr", 32'(ram_addr), 32'(exp_addr_q.pop_front()));
      end
      if (ram_we || host_ack) begin
        check("ack_with_we", 32'(host_ack), 32'(ram_we));
        if (ram_we) begin
          check("write_expected", 32'(exp_wr_q.size() != 0), 1);
          if (exp_wr_q.size() != 0) begin
            w = exp_wr_q.pop_front();
            check("wr_addr", 32'(ram_addr), 32'(w[31:16]));
            check("wr_data", 32'(ram_wdata), 32'(w[15:0]));
            check("write_state", 32'(dbg_state), 32'(ST_WRITE));
          end
        end
      end
      if (pix_empty) check("empty_pix_zero", 32'(pix_data), 0);
      if (pix_rd && !pix_empty) begin
        pops_in_line++;
        check("pix_expected", 32'(exp_pix_q.size() != 0), 1);
        if (exp_pix_q.size() != 0) check("pix_data", 32'(pix_data), 32'(exp_pix_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; line_start = 1'b0; line_base = '0; pix_rd = 1'b0;
    host_req = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ram_re", 32'(ram_re), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_wdata", 32'(ram_wdata), 0);
    check("rst_host_ack", 32'(host_ack), 0);
    check("rst_pix_empty", 32'(pix_empty), 1);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_pix_data", 32'(pix_data), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    reset = 1'b0;

    // Pop from an empty FIFO: sticky underrun, survives line_start.
    @(posedge clk); #1;
    pix_rd = 1'b1;
    @(negedge clk);
    check("underrun_pix_data", 32'(pix_data), 0);
    @(posedge clk); #1;
    pix_rd = 1'b0;
    @(negedge clk);
    check("underrun_set", 32'(underrun), 1);
    start_line(16'h2000);
    repeat (3) @(negedge clk);
    check("underrun_sticky", 32'(underrun), 1);

    // Reset during active fetching drops everything in flight.
    do_reset();
    repeat (4) begin
      @(negedge clk);
      check("post_rst_re", 32'(ram_re), 0);
      check("post_rst_ack", 32'(host_ack), 0);
      check("post_rst_empty", 32'(pix_empty), 1);
      check("post_rst_underrun", 32'(underrun), 0);
    end

    // No pops: prefetch stalls once the FIFO is fully reserved.
    start_line(16'h1000);
    repeat (40) @(negedge clk);
    check("stall_reads", reads_in_line, 16);
    check("stall_not_empty", 32'(pix_empty), 0);

    // Steady pop every 4 cycles drains the whole line without underrun.
    start_line(16'h1000);
    repeat (8) @(posedge clk);
    for (int i = 0; i < LW; i++) begin
      @(posedge clk); #1; pix_rd = 1'b1;
      @(posedge clk); #1; pix_rd = 1'b0;
      repeat (2) @(posedge clk);
    end
    repeat (20) @(negedge clk);
    check("steady_pops", pops_in_line, LW);
    check("steady_reads", reads_in_line, LW);
    check("steady_reads_left", exp_addr_q.size(), 0);
    check("steady_underrun", 32'(underrun), 0);

    // Host write while fetch runs at full rate.
    fork
      start_line(16'h3000);
      begin
        repeat (2) @(posedge clk);
        host_write(16'h8ABC, 16'hBEEF);
      end
    join

    // New line while reads are in flight: nothing stale reaches the FIFO.
    start_line(16'h4000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_flush_not_empty", 32'(pix_empty), 0);
    start_line(16'h5000);
    repeat (3) begin
      @(negedge clk);
      check("flush_empty", 32'(pix_empty), 1);
    end
    drain_line();

    // Randomised lines (including address wrap) with concurrent host traffic.
    fork
      begin
        run_line(16'hFFFE);
        for (int k = 0; k < 3; k++) run_line(16'($urandom_range(0, 28672)));
      end
      host_traffic(12);
    join
    repeat (10) @(negedge clk);
    check("writes_left", exp_wr_q.size(), 0);
    check("final_underrun", 32'(underrun), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
